clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//   Time-setting controller for the 12-hour BCD digital clock. Button-driven FSM freezes
//   the running counters, lets the user step hours then minutes on shadow registers, and
//   loads the result into the clock through a valid/ready handshake (seconds load as 00).
//   Sits between the debounced front-panel buttons and the clock core's load/enable inputs.
// PARAMETERS
//   CLK_FREQ   50_000_000  input clock frequency, Hz
//   BLINK_HZ   2           blink rate of the digit group being edited
//   TIMEOUT_S  10          seconds without a button press before an edit is abandoned
// PORTS
//   clk             in   1  system clock; the only clock
//   rst             in   1  synchronous, active-high reset
//   btn_mode        in   1  one-cycle pulse, debounced: advance edit step
//   btn_inc         in   1  one-cycle pulse, debounced: increment field being edited
//   cur_hour_tens   in   4  live clock hour tens (BCD, 0..1)
//   cur_hour_units  in   4  live clock hour units (BCD)
//   cur_min_tens    in   4  live clock minute tens (BCD, 0..5)
//   cur_min_units   in   4  live clock minute units (BCD)
//   cur_is_am       in   1  live clock AM flag
//   run_en          out  1  1 = clock counters advance; 0 = frozen for editing
//   load_valid      out  1  set_* bus valid; held until load_ready
//   load_ready      in   1  clock core accepts load this cycle
//   set_hour_tens   out  4  shadow hour tens
//   set_hour_units  out  4  shadow hour units
//   set_min_tens    out  4  shadow minute tens
//   set_min_units   out  4  shadow minute units
//   set_is_am       out  1  shadow AM flag
//   blink_hour      out  1  display blank strobe for hour digits
//   blink_min       out  1  display blank strobe for minute digits
//   busy            out  1  1 in any state other than RUN
// BEHAVIOUR
//   Reset: state RUN; run_en=1; load_valid=0; shadow=12:00 AM (1,2,0,0,am=1); blink_*=0; busy=0.
//   States: RUN -> SET_HR -> SET_MIN -> LOAD -> RUN. All outputs registered.
//   RUN: btn_mode -> capture cur_* into shadow same edge, run_en=0, go SET_HR next cycle.
//   SET_HR: btn_inc steps hour 1..12; 12->1 wraps; 11->12 toggles set_is_am; btn_mode -> SET_MIN.
//   SET_MIN: btn_inc steps 00..59; 59->00 wraps, no carry into hour; btn_mode -> LOAD.
//   LOAD: load_valid=1, set_* stable; cycle with load_valid&load_ready -> RUN; load_valid=0 and
//     run_en=1 from the next cycle. btn_* ignored in LOAD. No timeout in LOAD.
//   btn_mode and btn_inc same cycle: mode wins, inc dropped. btn_* ignored while rst=1.
//   Increment latency: shadow updates one cycle after the btn_inc pulse.
//   BCD rules: units 0..9 only; shadow never holds an illegal code (hour 00, 13+, min 60+).
//   Blink: phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles; phase forced to 1 on entry to
//     SET_HR/SET_MIN and on every btn_inc; blink_hour=phase&SET_HR; blink_min=phase&SET_MIN.
//   Reset mid-edit or mid-LOAD: immediate return to reset state, no load issued.
// CONFIGURATION
//   CLOCK_SET_TIMEOUT_EN defined: 1 Hz seconds counter cleared on state entry and any btn_*;
//     reaching TIMEOUT_S in SET_HR/SET_MIN -> RUN, run_en=1, no load (shadow discarded).
//   Not defined: no timeout counter; edit states wait indefinitely.
// STRUCTURE
//   Package clock_set_pkg: state enum (RUN, SET_HR, SET_MIN, LOAD), HOUR_MIN=1, HOUR_MAX=12,
//     MIN_MAX=59, reset shadow constants, BCD increment/wrap functions.
//   Sub-module clock_set_tick_gen: parameterised divider emitting blink_tick and sec_tick pulses.
// TESTING
//   Reset, then btn_mode -> busy=1, run_en=0, shadow equals cur_* (e.g. 03:47 PM).
//   From 11:xx AM in SET_HR, 1 inc -> 12 PM; 1 more inc -> 01 PM, am flag unchanged.
//   SET_MIN at 59, inc -> 00, hour unchanged; mode+inc same cycle -> SET_MIN->LOAD, min unchanged.
//   LOAD with load_ready low 5 cycles -> load_valid held, set_* stable; ready high -> RUN next.
//   CLOCK_SET_TIMEOUT_EN, TIMEOUT_S=2, small CLK_FREQ: idle in SET_HR -> RUN, load_valid never 1.
//   rst pulsed during LOAD -> load_valid=0, run_en=1, shadow 12:00 AM next cycle.

Source files
------------

// File: rtl/clock_set_pkg.sv
// clock_set_pkg: states, limits, reset shadow and BCD step/validity helpers for clock_set_ctrl
package clock_set_pkg;
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, LOAD} state_t;
  localparam int HOUR_MIN = 1;
  localparam int HOUR_MAX = 12;
  localparam int MIN_MAX = 59;
  localparam logic [7:0] RST_HOUR = 8'h12;
  localparam logic [7:0] RST_MIN = 8'h00;
  localparam logic RST_AM = 1'b1;
  function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
    return 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
  endfunction
  function automatic logic [7:0] bin2bcd(input logic [7:0] b);
    return {4'(b / 8'd10), 4'(b % 8'd10)};
  endfunction
  function automatic logic hour_ok(input logic [7:0] hr);
    return hr[3:0] <= 4'd9 && bcd2bin(hr) >= 8'(HOUR_MIN) && bcd2bin(hr) <= 8'(HOUR_MAX);
  endfunction
  function automatic logic min_ok(input logic [7:0] mn);
    return mn[3:0] <= 4'd9 && bcd2bin(mn) <= 8'(MIN_MAX);
  endfunction
  // 12 wraps to 1; 11 -> 12 flips the AM/PM flag
  function automatic logic [8:0] hour_inc(input logic [7:0] hr, input logic am);
    return {am ^ (bcd2bin(hr) == 8'(HOUR_MAX - 1)),
            bin2bcd((bcd2bin(hr) >= 8'(HOUR_MAX) || bcd2bin(hr) < 8'(HOUR_MIN)) ? 8'(HOUR_MIN) : bcd2bin(hr) + 8'd1)};
  endfunction
  // 59 wraps to 00 with no carry into the hour
  function automatic logic [7:0] min_inc(input logic [7:0] mn);
    return bin2bcd(bcd2bin(mn) >= 8'(MIN_MAX) ? 8'd0 : bcd2bin(mn) + 8'd1);
  endfunction
endpackage

// File: rtl/clock_set_tick_gen.sv
// clock_set_tick_gen: blink-phase divider and (with CLOCK_SET_TIMEOUT_EN) 1 Hz seconds divider
module clock_set_tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic blink_clr,
  output logic blink_tick
`ifdef CLOCK_SET_TIMEOUT_EN
  ,
  input  logic sec_clr,
  output logic sec_tick
`endif
);
  localparam int BLINK_DIV = (CLK_FREQ / (2 * BLINK_HZ)) > 1 ? CLK_FREQ / (2 * BLINK_HZ) : 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] bcnt;
  assign blink_tick = bcnt == BW'(BLINK_DIV - 1);
  // blink divider restarts whenever the phase is forced so the first half-period is full length
  always_ff @(posedge clk)
    bcnt <= (rst || blink_clr || blink_tick) ? '0 : bcnt + BW'(1);
`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int SEC_DIV = CLK_FREQ > 1 ? CLK_FREQ : 1;
  localparam int SW = $clog2(SEC_DIV + 1);
  logic [SW-1:0] scnt;
  assign sec_tick = scnt == SW'(SEC_DIV - 1);
  // seconds divider restarts on every button press and state entry
  always_ff @(posedge clk)
    scnt <= (rst || sec_clr || sec_tick) ? '0 : scnt + SW'(1);
`endif
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven time-setting FSM for the 12-hour BCD clock; optional edit timeout via CLOCK_SET_TIMEOUT_EN
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  input  logic       cur_is_am,
  output logic       run_en,
  output logic       load_valid,
  input  logic       load_ready,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_units,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_units,
  output logic       set_is_am,
  output logic       blink_hour,
  output logic       blink_min,
  output logic       busy
);
  state_t state;
  logic [7:0] hr, mn;
  logic am, phase, ph_n, edit, blink_tick, timeout;
  assign edit = state == SET_HR || state == SET_MIN;
  assign ph_n = blink_tick ? ~phase : phase;
  assign {set_hour_tens, set_hour_units} = hr;
  assign {set_min_tens, set_min_units} = mn;
  assign set_is_am = am;
`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  logic sec_tick, sec_clr;
  logic [TW-1:0] to_cnt;
  assign sec_clr = btn_mode | btn_inc | ~edit;
  assign timeout = sec_tick && to_cnt == TW'(TIMEOUT_S - 1);
  // idle seconds spent in an edit state
  always_ff @(posedge clk)
    to_cnt <= (rst || sec_clr) ? '0 : sec_tick ? to_cnt + TW'(1) : to_cnt;
  clock_set_tick_gen #(.CLK_FREQ(CLK_FREQ), .BLINK_HZ(BLINK_HZ)) u_tick (
    .clk(clk), .rst(rst), .blink_clr(btn_mode | btn_inc), .blink_tick(blink_tick),
    .sec_clr(sec_clr), .sec_tick(sec_tick));
`else
  assign timeout = 1'b0;
  clock_set_tick_gen #(.CLK_FREQ(CLK_FREQ), .BLINK_HZ(BLINK_HZ)) u_tick (
    .clk(clk), .rst(rst), .blink_clr(btn_mode | btn_inc), .blink_tick(blink_tick));
`endif
  // edit FSM; mode beats inc, buttons are ignored in LOAD, timeout abandons the edit without loading
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      run_en <= 1'b1;
      load_valid <= 1'b0;
      busy <= 1'b0;
      blink_hour <= 1'b0;
      blink_min <= 1'b0;
      phase <= 1'b0;
      hr <= RST_HOUR;
      mn <= RST_MIN;
      am <= RST_AM;
    end else begin
      case (state)
        RUN: if (btn_mode) begin
          state <= SET_HR;
          run_en <= 1'b0;
          busy <= 1'b1;
          phase <= 1'b1;
          blink_hour <= 1'b1;
          hr <= hour_ok({cur_hour_tens, cur_hour_units}) ? {cur_hour_tens, cur_hour_units} : RST_HOUR;
          mn <= min_ok({cur_min_tens, cur_min_units}) ? {cur_min_tens, cur_min_units} : RST_MIN;
          am <= cur_is_am;
        end
        SET_HR: if (btn_mode) begin
          state <= SET_MIN;
          phase <= 1'b1;
          blink_hour <= 1'b0;
          blink_min <= 1'b1;
        end else if (btn_inc) begin
          {am, hr} <= hour_inc(hr, am);
          phase <= 1'b1;
          blink_hour <= 1'b1;
        end else if (timeout) begin
          state <= RUN;
          run_en <= 1'b1;
          busy <= 1'b0;
          blink_hour <= 1'b0;
        end else begin
          phase <= ph_n;
          blink_hour <= ph_n;
        end
        SET_MIN: if (btn_mode) begin
          state <= LOAD;
          load_valid <= 1'b1;
          blink_min <= 1'b0;
        end else if (btn_inc) begin
          mn <= min_inc(mn);
          phase <= 1'b1;
          blink_min <= 1'b1;
        end else if (timeout) begin
          state <= RUN;
          run_en <= 1'b1;
          busy <= 1'b0;
          blink_min <= 1'b0;
        end else begin
          phase <= ph_n;
          blink_min <= ph_n;
        end
        LOAD: if (load_ready) begin
          state <= RUN;
          load_valid <= 1'b0;
          run_en <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and randomized checks of clock_set_ctrl against a behavioural time model
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst, btn_mode, btn_inc, load_ready, cur_is_am;
  logic [3:0] cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units;
  logic run_en, load_valid, set_is_am, blink_hour, blink_min, busy;
  logic [3:0] set_hour_tens, set_hour_units, set_min_tens, set_min_units;
  int n_cmp = 0, n_err = 0;
  int m_st, m_h, m_m;
  bit m_am;

  clock_set_ctrl #(.CLK_FREQ(20), .BLINK_HZ(2), .TIMEOUT_S(2)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour_tens(cur_hour_tens), .cur_hour_units(cur_hour_units),
    .cur_min_tens(cur_min_tens), .cur_min_units(cur_min_units), .cur_is_am(cur_is_am),
    .run_en(run_en), .load_valid(load_valid), .load_ready(load_ready),
    .set_hour_tens(set_hour_tens), .set_hour_units(set_hour_units),
    .set_min_tens(set_min_tens), .set_min_units(set_min_units), .set_is_am(set_is_am),
    .blink_hour(blink_hour), .blink_min(blink_min), .busy(busy));

  always #5 clk = ~clk;

  task automatic set_cur(input int h, input int m, input bit am);
    cur_hour_tens = 4'(h / 10);
    cur_hour_units = 4'(h % 10);
    cur_min_tens = 4'(m / 10);
    cur_min_units = 4'(m % 10);
    cur_is_am = am;
  endtask

  // one clock with the given buttons; the model applies the edit rules on plain integers
  task automatic step(input logic m, input logic i, input logic r);
    btn_mode = m;
    btn_inc = i;
    load_ready = r;
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_h = 12; m_m = 0; m_am = 1;
    end else if (m_st == 0) begin
      if (m) begin
        m_st = 1;
        m_h = cur_hour_tens * 10 + cur_hour_units;
        m_m = cur_min_tens * 10 + cur_min_units;
        m_am = cur_is_am;
      end
    end else if (m_st == 1) begin
      if (m) m_st = 2;
      else if (i) begin
        if (m_h == 11) m_am = !m_am;
        m_h = (m_h == 12) ? 1 : m_h + 1;
      end
    end else if (m_st == 2) begin
      if (m) m_st = 3;
      else if (i) m_m = (m_m + 1) % 60;
    end else if (r) m_st = 0;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    load_ready = 1'b0;
  endtask

  task automatic go_run();
    for (int k = 0; k < 8 && m_st != 0; k++) step(m_st != 3, 1'b0, m_st == 3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if ({run_en, load_valid, busy, blink_hour, blink_min} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 10000", {run_en, load_valid, busy, blink_hour, blink_min});
    end
    n_cmp++;
    if ({set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am} !== {16'h1200, 1'b1}) begin
      n_err++;
      $display("FAIL reset_shadow: got %h%h:%h%h am=%b want 12:00 am=1", set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am);
    end
  endtask

  task automatic test_capture();
    set_cur(3, 47, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({busy, run_en, blink_hour, blink_min, load_valid} !== 5'b10100) begin
      n_err++;
      $display("FAIL capture_ctrl: got %b want 10100", {busy, run_en, blink_hour, blink_min, load_valid});
    end
    n_cmp++;
    if ({set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am} !== {16'h0347, 1'b0}) begin
      n_err++;
      $display("FAIL capture_shadow: got %h%h:%h%h am=%b want 03:47 am=0", set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am);
    end
  endtask

  // half-period is 5 cycles with CLK_FREQ=20, BLINK_HZ=2
  task automatic test_blink();
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (blink_hour !== ((k / 5) % 2 == 0)) begin
        n_err++;
        $display("FAIL blink_phase k=%0d: got %b want %b", k, blink_hour, (k / 5) % 2 == 0);
      end
    end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({blink_hour, set_hour_tens, set_hour_units} !== {1'b1, 4'(m_h / 10), 4'(m_h % 10)}) begin
      n_err++;
      $display("FAIL blink_inc: got %b %h%h want 1 %0d", blink_hour, set_hour_tens, set_hour_units, m_h);
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({blink_hour, blink_min} !== 2'b01) begin
      n_err++;
      $display("FAIL blink_min_entry: got %b want 01", {blink_hour, blink_min});
    end
  endtask

  task automatic test_hour_step();
    go_run();
    set_cur(11, 25, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({set_hour_tens, set_hour_units, set_is_am} !== {8'h12, 1'b0}) begin
      n_err++;
      $display("FAIL hour_11_to_12: got %h%h am=%b want 12 am=0", set_hour_tens, set_hour_units, set_is_am);
    end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({set_hour_tens, set_hour_units, set_is_am} !== {8'h01, 1'b0}) begin
      n_err++;
      $display("FAIL hour_12_to_1: got %h%h am=%b want 01 am=0", set_hour_tens, set_hour_units, set_is_am);
    end
  endtask

  task automatic test_min_wrap();
    go_run();
    set_cur(7, 59, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({set_hour_tens, set_hour_units, set_min_tens, set_min_units} !== 16'h0700) begin
      n_err++;
      $display("FAIL min_wrap: got %h%h:%h%h want 07:00", set_hour_tens, set_hour_units, set_min_tens, set_min_units);
    end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({load_valid, set_min_tens, set_min_units} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL mode_beats_inc: got valid=%b min=%h%h want valid=1 min=00", load_valid, set_min_tens, set_min_units);
    end
  endtask

  task automatic test_load_stall();
    for (int k = 0; k < 5; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if ({load_valid, run_en, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am} !== {2'b10, 16'h0700, 1'b1}) begin
        n_err++;
        $display("FAIL load_stall k=%0d: got valid=%b run=%b %h%h:%h%h am=%b", k, load_valid, run_en, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({load_valid, run_en, busy} !== 3'b010) begin
      n_err++;
      $display("FAIL load_accept: got %b want 010", {load_valid, run_en, busy});
    end
  endtask

  task automatic test_reset_in_load();
    set_cur(5, 30, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    n_cmp++;
    if ({run_en, load_valid, busy, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am} !== {3'b100, 16'h1200, 1'b1}) begin
      n_err++;
      $display("FAIL reset_in_load: got run=%b valid=%b busy=%b %h%h:%h%h am=%b", run_en, load_valid, busy, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      set_cur($urandom_range(1, 12), $urandom_range(0, 59), 1'($urandom_range(0, 1)));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({run_en, load_valid, busy, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am} !==
          {m_st == 0, m_st == 3, m_st != 0, 4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), m_am}) begin
        n_err++;
        $display("FAIL random k=%0d: got run=%b valid=%b busy=%b %h%h:%h%h am=%b want st=%0d %0d:%0d am=%b", k, run_en, load_valid, busy, set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am, m_st, m_h, m_m, m_am);
      end
    end
  endtask

`ifdef CLOCK_SET_TIMEOUT_EN
  // TIMEOUT_S=2 at CLK_FREQ=20: 40 idle cycles abandon the edit
  task automatic test_timeout();
    bit seen = 1'b0;
    go_run();
    set_cur(2, 10, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 39; k++) begin
      step(1'b0, 1'b0, 1'b0);
      seen |= load_valid;
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: got busy=%b want 1", busy);
    end
    step(1'b0, 1'b0, 1'b0);
    seen |= load_valid;
    m_st = 0;
    n_cmp++;
    if ({run_en, busy, seen} !== 3'b100) begin
      n_err++;
      $display("FAIL timeout_exit: got run=%b busy=%b valid_seen=%b want 1 0 0", run_en, busy, seen);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    load_ready = 1'b0;
    set_cur(1, 0, 1'b1);
    m_st = 0; m_h = 12; m_m = 0; m_am = 1;
    test_reset();
    test_capture();
    test_blink();
    test_hour_step();
    test_min_wrap();
    test_load_stall();
    test_reset_in_load();
`ifdef CLOCK_SET_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
